// File: rtl/pipecleaner_checker_if.sv
// Bus between the pipecleaner checker and its surroundings: run control,
// adder operand/sum loop and the result/status fields.
interface pipecleaner_checker_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [7:0]       num_vec;
  logic [WIDTH-1:0] sum_in;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0] vec_cnt;
  logic [7:0]       fail_idx;
  logic [WIDTH-1:0] fail_got;
  logic [WIDTH-1:0] fail_exp;

  // Checker side
  modport master (
    input  start, abort, num_vec, sum_in,
    output op_a, op_b, busy, done, pass, err_cnt, vec_cnt,
           fail_idx, fail_got, fail_exp
  );

  // Environment side (controller plus the adder under check)
  modport slave (
    output start, abort, num_vec, sum_in,
    input  op_a, op_b, busy, done, pass, err_cnt, vec_cnt,
           fail_idx, fail_got, fail_exp
  );
endinterface

// File: rtl/pipecleaner_checker.sv
// Self-checking stimulus/response engine for the pipecleaner adder: drives
// LFSR operands, samples the returned sum LAT cycles later and scores it.
module pipecleaner_checker #(
  parameter int          WIDTH = 8,
  parameter int          LAT   = 2,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipecleaner_checker_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [3:0] LAT_LAST = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Sum in the adder's own width, so the carry out simply falls away.
  function automatic logic [WIDTH-1:0] add_wrap(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [7:0]       num_vec_q, num_vec_d;
  logic [7:0]       idx_q, idx_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [7:0]       fail_idx_q, fail_idx_d;
  logic [WIDTH-1:0] fail_got_q, fail_got_d;
  logic [WIDTH-1:0] fail_exp_q, fail_exp_d;
  logic             run_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED;
      num_vec_q  <= '0;
      idx_q      <= '0;
      wait_cnt_q <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      exp_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_cnt_q  <= '0;
      vec_cnt_q  <= '0;
      fail_idx_q <= '0;
      fail_got_q <= '0;
      fail_exp_q <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      num_vec_q  <= num_vec_d;
      idx_q      <= idx_d;
      wait_cnt_q <= wait_cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      exp_q      <= exp_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_cnt_q  <= err_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      fail_idx_q <= fail_idx_d;
      fail_got_q <= fail_got_d;
      fail_exp_q <= fail_exp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    num_vec_d  = num_vec_q;
    idx_d      = idx_q;
    wait_cnt_d = wait_cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    exp_d      = exp_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_cnt_d  = err_cnt_q;
    vec_cnt_d  = vec_cnt_q;
    fail_idx_d = fail_idx_q;
    fail_got_d = fail_got_q;
    fail_exp_d = fail_exp_q;
    run_active = (state_q == S_DRIVE) || (state_q == S_WAIT) ||
                 (state_q == S_CHECK);

    // Abort freezes every result register; only the control state drops.
    if (bus.abort && run_active) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start && !bus.abort) begin
            num_vec_d  = bus.num_vec;
            lfsr_d     = SEED;
            idx_d      = '0;
            err_cnt_d  = '0;
            vec_cnt_d  = '0;
            fail_idx_d = '0;
            fail_got_d = '0;
            fail_exp_d = '0;
            if (bus.num_vec == 8'd0) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              busy_d  = 1'b1;
              done_d  = 1'b0;
              state_d = S_DRIVE;
            end
          end
        end

        S_DRIVE: begin
          op_a_d     = WIDTH'(lfsr_q[7:0]);
          op_b_d     = WIDTH'(lfsr_q[15:8]);
          exp_d      = add_wrap(WIDTH'(lfsr_q[7:0]), WIDTH'(lfsr_q[15:8]));
          wait_cnt_d = '0;
          state_d    = (LAT > 0) ? S_WAIT : S_CHECK;
        end

        S_WAIT: begin
          if (wait_cnt_q == LAT_LAST) begin
            state_d = S_CHECK;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end

        S_CHECK: begin
          if (bus.sum_in != exp_q) begin
            err_cnt_d = sat_inc(err_cnt_q);
            // err_cnt only leaves zero on a mismatch, so zero marks the first one.
            if (err_cnt_q == '0) begin
              fail_idx_d = idx_q;
              fail_got_d = bus.sum_in;
              fail_exp_d = exp_q;
            end
          end
          vec_cnt_d = vec_cnt_q + CNT_W'(1);
          idx_d     = idx_q + 8'd1;
          lfsr_d    = lfsr_step(lfsr_q);
          if (idx_q + 8'd1 == num_vec_q) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DRIVE;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.op_a     = op_a_q;
  assign bus.op_b     = op_b_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = done_q && (err_cnt_q == '0);
  assign bus.err_cnt  = err_cnt_q;
  assign bus.vec_cnt  = vec_cnt_q;
  assign bus.fail_idx = fail_idx_q;
  assign bus.fail_got = fail_got_q;
  assign bus.fail_exp = fail_exp_q;

endmodule

// File: tb/tb_pipecleaner_checker.sv
// Bench for pipecleaner_checker: fixed vector table, hand-written corner
// sequences and randomized runs scored against an LFSR/adder reference model.
module tb_pipecleaner_checker;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipecleaner_checker_if #(.WIDTH(8), .CNT_W(16)) bus ();
  pipecleaner_checker_if #(.WIDTH(8), .CNT_W(4))  bus2 ();

  pipecleaner_checker #(.WIDTH(8), .LAT(2), .SEED(SEED), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  pipecleaner_checker #(.WIDTH(8), .LAT(0), .SEED(SEED), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  // Adder stand-in: loopback with per-vector corruption, or a constant.
  logic [7:0] xor_tab [256];
  logic       loop_mode;
  logic [7:0] const_val;
  assign bus.sum_in  = loop_mode ? ((bus.op_a + bus.op_b) ^ xor_tab[bus.vec_cnt[7:0]])
                                 : const_val;
  assign bus2.sum_in = 8'h00;

  int checks;
  int failures;

  typedef struct {
    logic [31:0] err, vec, pass, fidx, fgot, fexp, opa, opb;
  } res_t;

  typedef struct {
    logic        loop;
    logic [7:0]  cval;
    int          nv;
    int          cidx;
    logic [31:0] err, vec, pass, fidx, fgot, fexp;
    logic        chk_ops;
    logic [31:0] opa, opb;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Whole-run prediction from the rules: operand stream, wrapped sum, scoring.
  function automatic res_t model(input int nv, input logic loop, input logic [7:0] cval,
                                 input int sat);
    res_t r;
    int   l, a, b, e, got, err;
    r = '{default: 32'd0};
    l = int'(SEED);
    err = 0;
    for (int i = 0; i < nv; i++) begin
      a = l % 256;
      b = l / 256;
      e = (a + b) % 256;
      got = loop ? (e ^ int'(xor_tab[i])) : int'(cval);
      if (got != e) begin
        if (err == 0) begin
          r.fidx = 32'(i);
          r.fgot = 32'(got);
          r.fexp = 32'(e);
        end
        if (err < sat) err = err + 1;
      end
      r.opa = 32'(a);
      r.opb = 32'(b);
      l = ((l * 2) % 65536) + (((l >> 15) ^ (l >> 13) ^ (l >> 12) ^ (l >> 10)) & 1);
    end
    r.err  = 32'(err);
    r.vec  = 32'(nv);
    r.pass = (err == 0) ? 32'd1 : 32'd0;
    return r;
  endfunction

  task automatic clear_xor();
    for (int i = 0; i < 256; i++) xor_tab[i] = 8'h00;
  endtask

  // Called at a negedge; returns cycles from the first sample after start to done.
  task automatic run1(input int nv, output int cyc, output logic busy_seen);
    bus.num_vec = 8'(nv);
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    busy_seen = bus.busy;
    for (int c = 0; c < 4000 && !bus.done; c++) begin
      @(negedge clk);
      cyc++;
      busy_seen = busy_seen | bus.busy;
    end
    chk("run_done", 32'(bus.done), 32'd1);
  endtask

  task automatic check_res(input string tag, input res_t m, input logic ops);
    chk({tag, ".busy"},     32'(bus.busy),     32'd0);
    chk({tag, ".err_cnt"},  32'(bus.err_cnt),  m.err);
    chk({tag, ".vec_cnt"},  32'(bus.vec_cnt),  m.vec);
    chk({tag, ".pass"},     32'(bus.pass),     m.pass);
    chk({tag, ".fail_idx"}, 32'(bus.fail_idx), m.fidx);
    chk({tag, ".fail_got"}, 32'(bus.fail_got), m.fgot);
    chk({tag, ".fail_exp"}, 32'(bus.fail_exp), m.fexp);
    if (ops) begin
      chk({tag, ".op_a"}, 32'(bus.op_a), m.opa);
      chk({tag, ".op_b"}, 32'(bus.op_b), m.opb);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".op_a"},     32'(bus.op_a),     32'd0);
    chk({tag, ".op_b"},     32'(bus.op_b),     32'd0);
    chk({tag, ".busy"},     32'(bus.busy),     32'd0);
    chk({tag, ".done"},     32'(bus.done),     32'd0);
    chk({tag, ".pass"},     32'(bus.pass),     32'd0);
    chk({tag, ".err_cnt"},  32'(bus.err_cnt),  32'd0);
    chk({tag, ".vec_cnt"},  32'(bus.vec_cnt),  32'd0);
    chk({tag, ".fail_idx"}, 32'(bus.fail_idx), 32'd0);
    chk({tag, ".fail_got"}, 32'(bus.fail_got), 32'd0);
    chk({tag, ".fail_exp"}, 32'(bus.fail_exp), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "bench watchdog");
  end

  initial begin
    vec_t tbl [7];
    res_t m;
    int   cyc, lat;
    logic bsy;

    checks = 0;
    failures = 0;
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.num_vec = 8'd0;
    bus2.start = 1'b0; bus2.abort = 1'b0; bus2.num_vec = 8'd0;
    loop_mode = 1'b1;
    const_val = 8'h00;
    clear_xor();

    // loop, cval, nv, cidx, err, vec, pass, fidx, fgot, fexp, chk_ops, opa, opb
    tbl[0] = '{1'b1, 8'h00, 1, -1, 0, 1, 1, 0,    0,    0,    1'b1, 'hE1, 'hAC};
    tbl[1] = '{1'b0, 8'h00, 4, -1, 4, 4, 0, 0,    'h00, 'h8D, 1'b1, 'h0F, 'h67};
    tbl[2] = '{1'b1, 8'h00, 5,  2, 1, 5, 0, 2,    'h3B, 'h3A, 1'b1, 'h1E, 'hCE};
    tbl[3] = '{1'b1, 8'h00, 0, -1, 0, 0, 1, 0,    0,    0,    1'b0, 0,    0};
    tbl[4] = '{1'b1, 8'h00, 1, -1, 0, 1, 1, 0,    0,    0,    1'b1, 'hE1, 'hAC};
    tbl[5] = '{1'b0, 8'h8D, 2, -1, 1, 2, 0, 1,    'h8D, 'h1C, 1'b1, 'hC3, 'h59};
    tbl[6] = '{1'b1, 8'h00, 3, -1, 0, 3, 1, 0,    0,    0,    1'b1, 'h87, 'hB3};

    #1 rst = 1'b1;
    #1 check_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single loopback vector: first operands and LAT+2 latency to done
    loop_mode = 1'b1;
    bus.num_vec = 8'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("t1.busy", 32'(bus.busy), 32'd1);
    lat = 0;
    for (int c = 0; c < 20 && !bus.done; c++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("t1.op_a", 32'(bus.op_a), 32'hE1);
        chk("t1.op_b", 32'(bus.op_b), 32'hAC);
      end
    end
    chk("t1.latency", 32'(lat), 32'd4);
    chk("t1.pass", 32'(bus.pass), 32'd1);

    for (int k = 0; k < 7; k++) begin
      res_t exp_r;
      loop_mode = tbl[k].loop;
      const_val = tbl[k].cval;
      clear_xor();
      if (tbl[k].cidx >= 0) xor_tab[tbl[k].cidx] = 8'h01;
      run1(tbl[k].nv, cyc, bsy);
      exp_r = '{tbl[k].err, tbl[k].vec, tbl[k].pass, tbl[k].fidx, tbl[k].fgot,
                tbl[k].fexp, tbl[k].opa, tbl[k].opb};
      check_res($sformatf("tbl%0d", k), exp_r, tbl[k].chk_ops);
      chk($sformatf("tbl%0d.cycles", k), 32'(cyc), 32'(4 * tbl[k].nv));
      if (tbl[k].nv == 0) chk("tbl_empty.busy_seen", 32'(bsy), 32'd0);
    end

    // Abort after two vectors of ten; a start pulse mid-run must be ignored
    loop_mode = 1'b1;
    clear_xor();
    bus.num_vec = 8'd10;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.num_vec = 8'd1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.num_vec = 8'd10;
    for (int c = 0; c < 200 && bus.vec_cnt != 16'd2; c++) @(negedge clk);
    chk("abort.reach_vec2", 32'(bus.vec_cnt), 32'd2);
    chk("abort.no_early_done", 32'(bus.done), 32'd0);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("abort.busy", 32'(bus.busy), 32'd0);
    chk("abort.done", 32'(bus.done), 32'd0);
    chk("abort.vec_cnt", 32'(bus.vec_cnt), 32'd2);
    chk("abort.op_a", 32'(bus.op_a), 32'hC3);
    chk("abort.op_b", 32'(bus.op_b), 32'h59);
    repeat (6) @(negedge clk);
    chk("abort.stays_idle", 32'(bus.busy), 32'd0);
    chk("abort.vec_hold", 32'(bus.vec_cnt), 32'd2);

    // abort together with start in IDLE: start loses
    bus.num_vec = 8'd3;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("abort_start.busy", 32'(bus.busy), 32'd0);
    chk("abort_start.vec_cnt", 32'(bus.vec_cnt), 32'd2);

    // Asynchronous reset during WAIT, then a clean rerun from SEED
    bus.num_vec = 8'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("rstwait.ops_loaded", 32'(bus.op_a), 32'hE1);
    #2 rst = 1'b1;
    #1 check_zero("rstwait");
    @(negedge clk);
    rst = 1'b0;
    run1(3, cyc, bsy);
    m = model(3, 1'b1, 8'h00, 65535);
    check_res("after_rst", m, 1'b1);

    for (int r = 0; r < 30; r++) begin
      int nv;
      nv = $urandom_range(0, 12);
      loop_mode = ($urandom_range(0, 3) != 0);
      const_val = 8'($urandom_range(0, 255));
      for (int i = 0; i < 256; i++)
        xor_tab[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      m = model(nv, loop_mode, const_val, 65535);
      run1(nv, cyc, bsy);
      check_res($sformatf("rnd%0d", r), m, nv > 0);
      chk($sformatf("rnd%0d.cycles", r), 32'(cyc), 32'(4 * nv));
    end

    // Narrow counter instance with LAT=0: err_cnt must stop at all-ones
    bus2.num_vec = 8'd20;
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    for (int c = 0; c < 200 && !bus2.done; c++) @(negedge clk);
    m = model(20, 1'b0, 8'h00, 15);
    chk("sat.done", 32'(bus2.done), 32'd1);
    chk("sat.err_cnt", 32'(bus2.err_cnt), m.err);
    chk("sat.pass", 32'(bus2.pass), m.pass);
    chk("sat.fail_idx", 32'(bus2.fail_idx), m.fidx);
    chk("sat.fail_exp", 32'(bus2.fail_exp), m.fexp);
    chk("sat.op_a", 32'(bus2.op_a), m.opa);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
